sdram_read_ctrl: RTL and testbench

SDRAM read-burst engine, the read-side counterpart of the existing write path (write_req/fifo_rd_req/write_ack). On a request it issues ACTIVE, READ and PRECHARGE to the SDRAM, then captures one burst from SDRAM_DQ after the CAS latency. Each captured word is pushed into a downstream FIFO (e.g. display/image output), one word per S_CLK. SDRAM_TOP muxes this block's command bus onto the pins while rd_busy=1.

---
 rtl/sdram_pkg.sv | 37 +++
 rtl/sdram_rd_capture.sv | 60 ++++++
 rtl/sdram_read_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_sdram_read_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions for the read and write controllers:
// command encodings, FSM state codes and address field widths.
package sdram_pkg;

  localparam int ROW_W  = 12;
  localparam int COL_W  = 8;
  localparam int BANK_W = 2;
  localparam int DQ_W   = 16;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int LOC_W  = BANK_W + ROW_W + COL_W;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACT  = 3'd1;
  localparam logic [2:0] ST_TRCD = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_CAPT = 3'd4;
  localparam logic [2:0] ST_PRE  = 3'd5;
  localparam logic [2:0] ST_TRP  = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  // Bank is the most significant field so a linear add
  // carries col -> row -> bank and wraps at the top.
  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } sdram_loc_t;

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture: CAS-latency delay line plus burst word
// counter; registers DQ and strobes one word per cycle into the FIFO.
module sdram_rd_capture
  import sdram_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int CAS_LAT   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_issue_i,
  input  logic [DQ_W-1:0] dq_i,
  output logic            wr_req_o,
  output logic [DQ_W-1:0] wr_data_o,
  output logic            last_o
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  logic [CAS_LAT-1:0] dly_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q;
  logic [DQ_W-1:0]    data_q;
  logic               last_q;
  logic               cap_en;
  logic               last_word;

  // Data is on DQ from CAS_LAT cycles after READ until the
  // word counter wraps back to zero.
  assign cap_en    = dly_q[CAS_LAT-1] | (cnt_q != '0);
  assign last_word = (cnt_q == CNT_W'(BURST_LEN - 1));

  // Delay the READ issue by CAS_LAT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly_q <= '0;
    else        dly_q <= {dly_q[CAS_LAT-2:0], rd_issue_i};
  end

  // Count words and register DQ into the FIFO write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      req_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      req_q  <= cap_en;
      last_q <= cap_en & last_word;
      if (cap_en) begin
        cnt_q  <= last_word ? '0 : cnt_q + 1'b1;
        data_q <= dq_i;
      end
    end
  end

  assign wr_req_o  = req_q;
  assign wr_data_o = data_q;
  assign last_o    = last_q;

endmodule

// File: rtl/sdram_read_ctrl.sv
// SDRAM read-burst engine: ACTIVE, READ, capture, PRECHARGE.
// Option RD_ADDR_AUTO_INC_EN adds an auto-incrementing read pointer.
module sdram_read_ctrl
  import sdram_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int CAS_LAT   = 3,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              read_req,
  output logic              read_ack,
  output logic              rd_busy,
  input  logic [ADDR_W-1:0] sdram_rd_addr,
  input  logic [BANK_W-1:0] sdram_rd_bank,
`ifdef RD_ADDR_AUTO_INC_EN
  input  logic              rd_addr_load,
`endif
  input  logic              fifo_almost_full,
  output logic              fifo_wr_req,
  output logic [DQ_W-1:0]   fifo_wr_data,
  output logic              rd_cs,
  output logic              rd_ras,
  output logic              rd_cas,
  output logic              rd_we,
  output logic [BANK_W-1:0] rd_bank,
  output logic [ROW_W-1:0]  rd_addr,
  output logic [1:0]        rd_dqm,
  input  logic [DQ_W-1:0]   SDRAM_DQ_IN
);

  localparam logic [COL_W-1:0] COL_MASK = ~COL_W'(BURST_LEN - 1);
  localparam logic [7:0] TRCD_INIT = 8'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [7:0] TRP_INIT  = 8'(T_RP - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        tmr_q, tmr_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [1:0]        dqm_q, dqm_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [BANK_W-1:0] lbank_q, lbank_d;

  sdram_loc_t        in_loc;
  sdram_loc_t        src_loc;
  logic [COL_W-1:0]  src_col;
  logic              accept;
  logic              cap_last;

  assign in_loc  = sdram_loc_t'({sdram_rd_bank, sdram_rd_addr});
  assign accept  = (state_q == ST_IDLE) & read_req & ~fifo_almost_full;
  assign src_col = src_loc.col & COL_MASK;

`ifdef RD_ADDR_AUTO_INC_EN
  sdram_loc_t ptr_q, ptr_d;
  sdram_loc_t pend_loc_q, pend_loc_d;
  logic       pend_q, pend_d;

  // A load seen while busy is parked and applied back in IDLE
  always_comb begin
    src_loc = ptr_q;
    if (rd_addr_load) src_loc = in_loc;
    else if (pend_q)  src_loc = pend_loc_q;
  end

  // Pointer update: load/pending in IDLE, advance per burst
  always_comb begin
    ptr_d      = ptr_q;
    pend_d     = pend_q;
    pend_loc_d = pend_loc_q;
    if (state_q == ST_IDLE) begin
      pend_d = 1'b0;
      if (accept)
        ptr_d = sdram_loc_t'({src_loc.bank, src_loc.row, src_col}
                             + LOC_W'(BURST_LEN));
      else
        ptr_d = src_loc;
    end else if (rd_addr_load) begin
      pend_d     = 1'b1;
      pend_loc_d = in_loc;
    end
  end

  // Pointer registers
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      pend_loc_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      pend_loc_q <= pend_loc_d;
    end
  end
`else
  assign src_loc = in_loc;
`endif

  // Burst sequencer; each state's command is registered on entry
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    dqm_d   = dqm_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    col_d   = col_q;
    lbank_d = lbank_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACT;
          cmd_d   = CMD_ACT;
          addr_d  = src_loc.row;
          bank_d  = src_loc.bank;
          col_d   = src_col;
          lbank_d = src_loc.bank;
          busy_d  = 1'b1;
          dqm_d   = 2'b00;
        end
      end
      ST_ACT: begin
        if (T_RCD == 1) begin
          state_d = ST_RD;
          cmd_d   = CMD_RD;
          addr_d  = {4'b0000, col_q};
          bank_d  = lbank_q;
        end else begin
          state_d = ST_TRCD;
          cmd_d   = CMD_NOP;
          tmr_d   = TRCD_INIT;
        end
      end
      ST_TRCD: begin
        if (tmr_q == 8'd0) begin
          state_d = ST_RD;
          cmd_d   = CMD_RD;
          addr_d  = {4'b0000, col_q};
          bank_d  = lbank_q;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_RD: begin
        state_d = ST_CAPT;
        cmd_d   = CMD_NOP;
      end
      ST_CAPT: begin
        if (cap_last) begin
          state_d = ST_PRE;
          cmd_d   = CMD_PRE;
          addr_d  = 12'h400;
        end
      end
      ST_PRE: begin
        state_d = ST_TRP;
        cmd_d   = CMD_NOP;
        tmr_d   = TRP_INIT;
      end
      ST_TRP: begin
        if (tmr_q == 8'd0) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          dqm_d   = 2'b11;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and command output registers
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      bank_q  <= '0;
      dqm_q   <= 2'b11;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      col_q   <= '0;
      lbank_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      dqm_q   <= dqm_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      col_q   <= col_d;
      lbank_q <= lbank_d;
    end
  end

  sdram_rd_capture #(
    .BURST_LEN (BURST_LEN),
    .CAS_LAT   (CAS_LAT)
  ) u_cap (
    .clk        (S_CLK),
    .rst_n      (RST_N),
    .rd_issue_i (state_q == ST_RD),
    .dq_i       (SDRAM_DQ_IN),
    .wr_req_o   (fifo_wr_req),
    .wr_data_o  (fifo_wr_data),
    .last_o     (cap_last)
  );

  assign rd_cs    = cmd_q[3];
  assign rd_ras   = cmd_q[2];
  assign rd_cas   = cmd_q[1];
  assign rd_we    = cmd_q[0];
  assign rd_bank  = bank_q;
  assign rd_addr  = addr_q;
  assign rd_dqm   = dqm_q;
  assign rd_busy  = busy_q;
  assign read_ack = ack_q;

endmodule

// File: tb/tb_sdram_read_ctrl.sv
// Directed bench for sdram_read_ctrl: CL=3 and CL=2 instances
// share stimulus; a small SDRAM read model drives DQ for each.
module tb_sdram_read_ctrl;
  import sdram_pkg::*;

  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_req = 1'b0;
  logic        almost_full = 1'b0;
  logic [19:0] addr = '0;
  logic [1:0]  bank = '0;
`ifdef RD_ADDR_AUTO_INC_EN
  logic        load = 1'b0;
`endif

  logic [15:0] dq [2];
  logic        cs [2], ras [2], cas [2], we [2];
  logic [3:0]  cmd [2];
  logic [11:0] oaddr [2];
  logic [1:0]  obank [2], dqm [2];
  logic        busy [2], ack [2], wr [2];
  logic [15:0] wdata [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cyc = 0;

  int nact [2], act_cyc [2], act_row [2], act_bank [2];
  int rd_cyc [2], rd_col [2], rd_bank [2], rd_hi [2];
  int pre_cyc [2], pre_a10 [2], ack_cyc [2];
  int nstb [2], first_stb [2];
  bit ack_seen [2], t0v [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_cmd
    assign cmd[g] = {cs[g], ras[g], cas[g], we[g]};
  end

  sdram_read_ctrl #(.CAS_LAT(3)) u_dut (
    .S_CLK(clk), .RST_N(rst_n), .read_req(read_req),
    .read_ack(ack[0]), .rd_busy(busy[0]),
    .sdram_rd_addr(addr), .sdram_rd_bank(bank),
`ifdef RD_ADDR_AUTO_INC_EN
    .rd_addr_load(load),
`endif
    .fifo_almost_full(almost_full),
    .fifo_wr_req(wr[0]), .fifo_wr_data(wdata[0]),
    .rd_cs(cs[0]), .rd_ras(ras[0]), .rd_cas(cas[0]), .rd_we(we[0]),
    .rd_bank(obank[0]), .rd_addr(oaddr[0]), .rd_dqm(dqm[0]),
    .SDRAM_DQ_IN(dq[0])
  );

  sdram_read_ctrl #(.CAS_LAT(2)) u_dut_cl2 (
    .S_CLK(clk), .RST_N(rst_n), .read_req(read_req),
    .read_ack(ack[1]), .rd_busy(busy[1]),
    .sdram_rd_addr(addr), .sdram_rd_bank(bank),
`ifdef RD_ADDR_AUTO_INC_EN
    .rd_addr_load(load),
`endif
    .fifo_almost_full(almost_full),
    .fifo_wr_req(wr[1]), .fifo_wr_data(wdata[1]),
    .rd_cs(cs[1]), .rd_ras(ras[1]), .rd_cas(cas[1]), .rd_we(we[1]),
    .rd_bank(obank[1]), .rd_addr(oaddr[1]), .rd_dqm(dqm[1]),
    .SDRAM_DQ_IN(dq[1])
  );

  function automatic int cl_of(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  function automatic logic [15:0] mem_word(input int a);
    return 16'haffa ^ 16'(a);
  endfunction

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SDRAM read model: word k of the burst sits on DQ at t0+CL+k
  always @* begin
    for (int i = 0; i < 2; i++) begin
      dq[i] = 16'h0000;
      if (t0v[i] && cyc >= rd_cyc[i] + cl_of(i)
          && cyc < rd_cyc[i] + cl_of(i) + BL)
        dq[i] = mem_word(rd_col[i] + cyc - rd_cyc[i] - cl_of(i));
    end
  end

  // Command/strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (cmd[i] == CMD_ACT) begin
          nact[i]++;
          act_cyc[i]  = cyc;
          act_row[i]  = int'(oaddr[i]);
          act_bank[i] = int'(obank[i]);
        end
        if (cmd[i] == CMD_RD) begin
          rd_cyc[i]  = cyc;
          rd_col[i]  = int'(oaddr[i][7:0]);
          rd_hi[i]   = int'(oaddr[i][11:8]);
          rd_bank[i] = int'(obank[i]);
          t0v[i]     = 1'b1;
        end
        if (cmd[i] == CMD_PRE) begin
          pre_cyc[i] = cyc;
          pre_a10[i] = int'(oaddr[i][10]);
        end
        if (wr[i]) begin
          if (nstb[i] == 0) first_stb[i] = cyc;
          check_eq($sformatf("data%0d_w%0d", i, nstb[i]),
                   32'(wdata[i]), 32'(mem_word(rd_col[i] + nstb[i])));
          nstb[i]++;
        end
        if (ack[i]) begin
          ack_seen[i] = 1'b1;
          ack_cyc[i]  = cyc;
        end
      end
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      nstb[i]      = 0;
      first_stb[i] = -1;
      ack_seen[i]  = 1'b0;
    end
  endtask

  task automatic start_burst(input logic [19:0] a,
                             input logic [1:0] b,
                             input bit ld);
    @(negedge clk);
    addr     = a;
    bank     = b;
    read_req = 1'b1;
`ifdef RD_ADDR_AUTO_INC_EN
    load     = ld;
`endif
    req_cyc  = cyc;
    @(negedge clk);
    read_req = 1'b0;
`ifdef RD_ADDR_AUTO_INC_EN
    load     = 1'b0;
`endif
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(ack_seen[0] && ack_seen[1]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, 32'(ack_seen[0] && ack_seen[1]), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0;
    int n;
    clear_mon();

    // Reset state
    #12;
    check_eq("rst_cmd", 32'(cmd[0]), 32'(CMD_NOP));
    check_eq("rst_dqm", 32'(dqm[0]), 32'h3);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_ack", 32'(ack[0]), 32'd0);
    check_eq("rst_wr", 32'(wr[0]), 32'd0);
    check_eq("rst_addr", 32'(oaddr[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single burst, both CAS latencies
    clear_mon();
    start_burst(20'h12340, 2'd1, 1'b1);
    check_eq("t1_busy", 32'(busy[0]), 32'd1);
    wait_done("t1");
    check_eq("t1_act_lat", 32'(act_cyc[0] - req_cyc), 32'd1);
    check_eq("t1_row", 32'(act_row[0]), 32'h123);
    check_eq("t1_act_bank", 32'(act_bank[0]), 32'd1);
    check_eq("t1_col", 32'(rd_col[0]), 32'h40);
    check_eq("t1_rd_hi", 32'(rd_hi[0]), 32'h0);
    check_eq("t1_rd_bank", 32'(rd_bank[0]), 32'd1);
    check_eq("t1_trcd", 32'(rd_cyc[0] - act_cyc[0]), 32'd2);
    check_eq("t1_cl3_lat", 32'(first_stb[0] - rd_cyc[0]), 32'd4);
    check_eq("t1_cl3_cnt", 32'(nstb[0]), 32'd8);
    check_eq("t1_cl2_lat", 32'(first_stb[1] - rd_cyc[1]), 32'd3);
    check_eq("t1_cl2_cnt", 32'(nstb[1]), 32'd8);
    check_eq("t1_a10", 32'(pre_a10[0]), 32'd1);
    check_eq("t1_trp", 32'(ack_cyc[0] - pre_cyc[0]), 32'd3);
    check_eq("t1_idle_busy", 32'(busy[0]), 32'd0);
    check_eq("t1_idle_dqm", 32'(dqm[0]), 32'h3);

    // Back-pressure holds off acceptance
    clear_mon();
    n0 = nact[0];
    @(negedge clk);
    almost_full = 1'b1;
    addr        = 20'h2a5c0;
    bank        = 2'd2;
    read_req    = 1'b1;
`ifdef RD_ADDR_AUTO_INC_EN
    load        = 1'b1;
`endif
    repeat (5) @(negedge clk);
    check_eq("bp_busy", 32'(busy[0]), 32'd0);
    check_eq("bp_noact", 32'(nact[0] - n0), 32'd0);
    almost_full = 1'b0;
    req_cyc     = cyc;
    @(negedge clk);
    read_req    = 1'b0;
`ifdef RD_ADDR_AUTO_INC_EN
    load        = 1'b0;
`endif
    wait_done("bp");
    check_eq("bp_act_lat", 32'(act_cyc[0] - req_cyc), 32'd1);
    check_eq("bp_one_act", 32'(nact[0] - n0), 32'd1);
    check_eq("bp_row", 32'(act_row[0]), 32'h2a5);
    check_eq("bp_col", 32'(rd_col[0]), 32'hc0);
    check_eq("bp_cnt", 32'(nstb[0]), 32'd8);

    // Unaligned column is forced to the burst boundary
    clear_mon();
    start_burst(20'h00005, 2'd2, 1'b1);
    wait_done("ua");
    check_eq("ua_col", 32'(rd_col[0]), 32'h00);
    check_eq("ua_row", 32'(act_row[0]), 32'h000);
    check_eq("ua_bank", 32'(rd_bank[0]), 32'd2);
    check_eq("ua_trp", 32'(ack_cyc[0] - pre_cyc[0]), 32'd3);
    check_eq("ua_cnt", 32'(nstb[0]), 32'd8);

    // Reset in the middle of capture
    clear_mon();
    start_burst(20'h0ab80, 2'd0, 1'b1);
    n = 0;
    while (nstb[0] < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("mr_reached", 32'(nstb[0] >= 3), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_cmd", 32'(cmd[0]), 32'(CMD_NOP));
    check_eq("mr_wr", 32'(wr[0]), 32'd0);
    check_eq("mr_busy", 32'(busy[0]), 32'd0);
    check_eq("mr_data", 32'(wdata[0]), 32'd0);
    check_eq("mr_dqm", 32'(dqm[0]), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    start_burst(20'h0ab80, 2'd0, 1'b1);
    wait_done("mr2");
    check_eq("mr2_row", 32'(act_row[0]), 32'h0ab);
    check_eq("mr2_col", 32'(rd_col[0]), 32'h80);
    check_eq("mr2_cnt0", 32'(nstb[0]), 32'd8);
    check_eq("mr2_cnt1", 32'(nstb[1]), 32'd8);

`ifdef RD_ADDR_AUTO_INC_EN
    // Pointer wraps from the top of bank 3 to bank 0 row 0 col 0
    @(negedge clk);
    load = 1'b1;
    addr = 20'hffff8;
    bank = 2'd3;
    @(negedge clk);
    load = 1'b0;
    clear_mon();
    start_burst(20'h55555, 2'd1, 1'b0);
    wait_done("ai1");
    check_eq("ai1_row", 32'(act_row[0]), 32'hfff);
    check_eq("ai1_bank", 32'(act_bank[0]), 32'd3);
    check_eq("ai1_col", 32'(rd_col[0]), 32'hf8);
    clear_mon();
    start_burst(20'h55555, 2'd1, 1'b0);
    wait_done("ai2");
    check_eq("ai2_row", 32'(act_row[0]), 32'h000);
    check_eq("ai2_bank", 32'(act_bank[0]), 32'd0);
    check_eq("ai2_col", 32'(rd_col[0]), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
